cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates completed results from N_REQ functional-unit outputs (ALUs, multiplier, branch, load) onto CDB_PORTS common-data-bus broadcast slots per cycle.
- Sits between the FU wrappers and the reservation stations, physical register file and ROB.
- Grants are round-robin, with a priority class and anti-starvation aging. Broadcast is registered, giving one cycle of latency.

Parameters:
N_REQ, 4, number of FU result requesters
CDB_PORTS, 2, broadcast slots per cycle (1..N_REQ)
PRF_W, 6, physical register index width
ROB_W, 3, ROB index width
PRIO_MASK, 4'b0001, requesters granted ahead of round-robin order (bit i = requester i)
STARVE_LIMIT, 8, consecutive denied valid cycles before a forced grant

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  pipeline flush (mispredict)
req_valid[N_REQ]  in  1  requester has a result
req_ready[N_REQ]  out  1  grant; transfer occurs when valid && ready
req_prd[N_REQ]  in  PRF_W  destination physical register
req_rob[N_REQ]  in  ROB_W  ROB index
req_data[N_REQ]  in  32  result value
req_regwrite[N_REQ]  in  1  result writes the register file
cdb_valid[CDB_PORTS]  out  1  slot valid
cdb_prd[CDB_PORTS]  out  PRF_W  broadcast tag
cdb_rob[CDB_PORTS]  out  ROB_W  broadcast ROB index
cdb_data[CDB_PORTS]  out  32  broadcast value
cdb_regwrite[CDB_PORTS]  out  1  broadcast regwrite

Behaviour:
- Reset (rst=0, asynchronous):
  - All cdb_* outputs go to 0.
  - rr_ptr resets to 0; all wait counters reset to 0.
  - req_ready is 0 while reset is asserted.
- Handshake:
  - req_ready is combinational from req_valid and state.
  - req_valid must not depend on req_ready.
  - A requester holds valid/payload stable until granted.
  - req_ready is never 1 when req_valid is 0.
- Grant selection per cycle fills slots in ascending port order, at most CDB_PORTS grants, in three tiers:
  1. Starved requesters (wait counter == STARVE_LIMIT), lowest index first.
  2. PRIO_MASK requesters that are valid, scanning from rr_ptr with wrap.
  3. Remaining valid requesters, scanning from rr_ptr upward with wrap modulo N_REQ.
- A requester is granted at most once per cycle.
- Broadcast:
  - Granted payload appears on the assigned cdb slot at the next rising edge.
  - Latency is exactly 1 cycle.
  - Ungranted slots have cdb_valid=0; their payload fields hold their previous value (don't-care).
- rr_ptr:
  - Advances to (highest-ordered tier-3 granted index + 1) mod N_REQ.
  - Unchanged if tier 3 granted nothing.
- Wait counters:
  - Increment (saturating at STARVE_LIMIT) while valid && !ready.
  - Clear on grant or when valid=0.
- flush:
  - In the flush cycle: all req_ready=0, and the next-edge cdb_valid are all 0.
  - Wait counters clear; rr_ptr is unchanged.
  - Requesters are responsible for dropping their own flushed results.
- Slot 0 is always filled before slot 1. No bubble slots appear while valid requesters remain ungranted.
- Payload passes through unmodified, including regwrite=0 results (stores, branches), so the ROB can mark them complete.

Test Plan:
1. Async reset: with cdb_valid=2'b11, drop rst between clock edges. Required: cdb_valid=0 and req_ready=0 immediately, before the next edge. After release, rr_ptr=0.
2. All four valid, PRIO_MASK=0, rr_ptr=0. Required:
   - Cycle 0 grants req0→port0 and req1→port1.
   - Next cycle: cdb_data = {d0, d1}, rr_ptr=2.
   - Cycle 1 grants req2 and req3; rr_ptr wraps to 0.
3. Only req3 valid, rr_ptr=0. Required: req_ready=4'b1000; next cycle cdb_valid=2'b01 and cdb_prd[0]=req_prd[3]; rr_ptr=0.
4. PRIO_MASK=4'b0001, req0..req3 all continuously valid with req0 re-asserting each cycle. Required:
   - req0 takes port0 every cycle.
   - req1/2/3 share port1 round-robin.
   - No requester's wait counter exceeds STARVE_LIMIT.
   - A forced grant occurs exactly when a counter reaches 8.
5. Flush with req1 and req2 valid. Required: req_ready=0 that cycle, cdb_valid=0 next cycle, wait counters 0.
6. req2 valid, regwrite=0, data=32'hDEADBEEF, rob=5. Required next cycle: cdb_valid[0]=1, cdb_regwrite[0]=0, cdb_rob[0]=5, cdb_data[0]=32'hDEADBEEF.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Bundle between the FU result requesters and the CDB arbiter. The master side is
// the FU wrappers and CDB consumers. The slave side is the arbiter itself.
interface cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int CDB_PORTS = 2,
  parameter int PRF_W     = 6,
  parameter int ROB_W     = 3
);
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0][PRF_W-1:0]      req_prd;
  logic [N_REQ-1:0][ROB_W-1:0]      req_rob;
  logic [N_REQ-1:0][31:0]           req_data;
  logic [N_REQ-1:0]                 req_regwrite;

  logic [CDB_PORTS-1:0]             cdb_valid;
  logic [CDB_PORTS-1:0][PRF_W-1:0]  cdb_prd;
  logic [CDB_PORTS-1:0][ROB_W-1:0]  cdb_rob;
  logic [CDB_PORTS-1:0][31:0]       cdb_data;
  logic [CDB_PORTS-1:0]             cdb_regwrite;

  modport master (
    output req_valid, req_prd, req_rob, req_data, req_regwrite,
    input  req_ready,
    input  cdb_valid, cdb_prd, cdb_rob, cdb_data, cdb_regwrite
  );

  modport slave (
    input  req_valid, req_prd, req_rob, req_data, req_regwrite,
    output req_ready,
    output cdb_valid, cdb_prd, cdb_rob, cdb_data, cdb_regwrite
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to CDB_PORTS finished FU results per cycle
// (starved first, then priority class, then round-robin) and broadcasts them one cycle later.
module cdb_arbiter #(
  parameter int                N_REQ        = 4,
  parameter int                CDB_PORTS    = 2,
  parameter int                PRF_W        = 6,
  parameter int                ROB_W        = 3,
  parameter logic [N_REQ-1:0]  PRIO_MASK    = N_REQ'(1),
  parameter int                STARVE_LIMIT = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          flush_i,
  cdb_arbiter_if.slave bus
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [IDX_W-1:0]                 rrPtr_q, rrPtr_d;
  logic [N_REQ-1:0][WAIT_W-1:0]     waitCnt_q, waitCnt_d;
  logic [N_REQ-1:0]                 grant;
  logic [CDB_PORTS-1:0]             portValid;
  logic [CDB_PORTS-1:0][IDX_W-1:0]  portSrc;

  logic [CDB_PORTS-1:0]             cdbValid_q;
  logic [CDB_PORTS-1:0][PRF_W-1:0]  cdbPrd_q;
  logic [CDB_PORTS-1:0][ROB_W-1:0]  cdbRob_q;
  logic [CDB_PORTS-1:0][31:0]       cdbData_q;
  logic [CDB_PORTS-1:0]             cdbRegwrite_q;

  always_comb begin : selectGrants
    logic [N_REQ-1:0]                g;
    logic [CDB_PORTS-1:0]            pv;
    logic [CDB_PORTS-1:0][IDX_W-1:0] ps;
    logic [IDX_W-1:0]                nextRr;
    logic [IDX_W-1:0]                idx;
    int                              used;
    g      = '0;
    pv     = '0;
    ps     = '0;
    nextRr = rrPtr_q;
    idx    = '0;
    used   = 0;
    waitCnt_d = '0;

    // Nothing is granted while in reset or during a flush cycle.
    if (rst_ni && !flush_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (used < CDB_PORTS && bus.req_valid[i] && waitCnt_q[i] == LIMIT) begin
          g[i]     = 1'b1;
          pv[used] = 1'b1;
          ps[used] = IDX_W'(i);
          used     = used + 1;
        end
      end
      for (int k = 0; k < N_REQ; k++) begin
        idx = IDX_W'((int'(rrPtr_q) + k) % N_REQ);
        if (used < CDB_PORTS && bus.req_valid[idx] && PRIO_MASK[idx] && !g[idx]) begin
          g[idx]   = 1'b1;
          pv[used] = 1'b1;
          ps[used] = idx;
          used     = used + 1;
        end
      end
      // Only round-robin grants move the pointer, so starved/priority wins keep fairness intact.
      for (int k = 0; k < N_REQ; k++) begin
        idx = IDX_W'((int'(rrPtr_q) + k) % N_REQ);
        if (used < CDB_PORTS && bus.req_valid[idx] && !g[idx]) begin
          g[idx]   = 1'b1;
          pv[used] = 1'b1;
          ps[used] = idx;
          used     = used + 1;
          nextRr   = IDX_W'((int'(idx) + 1) % N_REQ);
        end
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (!flush_i && bus.req_valid[i] && !g[i]) begin
        waitCnt_d[i] = (waitCnt_q[i] == LIMIT) ? LIMIT : waitCnt_q[i] + WAIT_W'(1);
      end
    end

    grant     = g;
    portValid = pv;
    portSrc   = ps;
    rrPtr_d   = nextRr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr_q       <= '0;
      waitCnt_q     <= '0;
      cdbValid_q    <= '0;
      cdbPrd_q      <= '0;
      cdbRob_q      <= '0;
      cdbData_q     <= '0;
      cdbRegwrite_q <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      waitCnt_q  <= waitCnt_d;
      cdbValid_q <= portValid;
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (portValid[p]) begin
          cdbPrd_q[p]      <= bus.req_prd[portSrc[p]];
          cdbRob_q[p]      <= bus.req_rob[portSrc[p]];
          cdbData_q[p]     <= bus.req_data[portSrc[p]];
          cdbRegwrite_q[p] <= bus.req_regwrite[portSrc[p]];
        end
      end
    end
  end

  assign bus.req_ready    = grant;
  assign bus.cdb_valid    = cdbValid_q;
  assign bus.cdb_prd      = cdbPrd_q;
  assign bus.cdb_rob      = cdbRob_q;
  assign bus.cdb_data     = cdbData_q;
  assign bus.cdb_regwrite = cdbRegwrite_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a plain round-robin instance, a priority instance
// and a single-port instance that exposes the starvation override.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rstN;
  logic flushRr, flushPrio, flushStarve;
  int   checkCount = 0;
  int   errorCount = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(4), .CDB_PORTS(2), .PRF_W(6), .ROB_W(3)) ifRr();
  cdb_arbiter_if #(.N_REQ(4), .CDB_PORTS(2), .PRF_W(6), .ROB_W(3)) ifPrio();
  cdb_arbiter_if #(.N_REQ(4), .CDB_PORTS(1), .PRF_W(6), .ROB_W(3)) ifStarve();

  cdb_arbiter #(.N_REQ(4), .CDB_PORTS(2), .PRF_W(6), .ROB_W(3),
                .PRIO_MASK(4'b0000), .STARVE_LIMIT(8)) dutRr (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flushRr), .bus(ifRr));

  cdb_arbiter #(.N_REQ(4), .CDB_PORTS(2), .PRF_W(6), .ROB_W(3),
                .PRIO_MASK(4'b0001), .STARVE_LIMIT(8)) dutPrio (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flushPrio), .bus(ifPrio));

  cdb_arbiter #(.N_REQ(4), .CDB_PORTS(1), .PRF_W(6), .ROB_W(3),
                .PRIO_MASK(4'b0001), .STARVE_LIMIT(8)) dutStarve (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flushStarve), .bus(ifStarve));

  // Requester i carries prd 10+i / 20+i / 30+i per instance, rob i, data A0000000+i.
  task automatic test_reset();
    rstN = 1'b0;
    flushRr = 1'b0; flushPrio = 1'b0; flushStarve = 1'b0;
    ifPrio.req_valid = '0;
    ifStarve.req_valid = '0;
    ifRr.req_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ifRr.req_prd[i] = 6'(10 + i);     ifPrio.req_prd[i] = 6'(20 + i);     ifStarve.req_prd[i] = 6'(30 + i);
      ifRr.req_rob[i] = 3'(i);          ifPrio.req_rob[i] = 3'(i);          ifStarve.req_rob[i] = 3'(i);
      ifRr.req_data[i] = 32'hA0000000 + 32'(i);
      ifPrio.req_data[i] = 32'hB0000000 + 32'(i);
      ifStarve.req_data[i] = 32'hC0000000 + 32'(i);
      ifRr.req_regwrite[i] = 1'b1;      ifPrio.req_regwrite[i] = 1'b1;      ifStarve.req_regwrite[i] = 1'b1;
    end
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0000) begin
      errorCount++; $display("[TB] FAIL reset_ready: got %b expected 0000", ifRr.req_ready);
    end
    checkCount++;
    if (ifRr.cdb_valid !== 2'b00 || ifPrio.cdb_valid !== 2'b00 || ifStarve.cdb_valid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL reset_cdb_valid: got %b/%b/%b expected 0", ifRr.cdb_valid, ifPrio.cdb_valid, ifStarve.cdb_valid);
    end
    checkCount++;
    if (dutRr.rrPtr_q !== 2'd0 || dutRr.waitCnt_q !== '0) begin
      errorCount++; $display("[TB] FAIL reset_state: got rr=%0d wait=%h expected 0/0", dutRr.rrPtr_q, dutRr.waitCnt_q);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
    rstN = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ifRr.req_valid = 4'hF;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0011) begin
      errorCount++; $display("[TB] FAIL async_pre_ready: got %b expected 0011", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b11 || dutRr.rrPtr_q !== 2'd2) begin
      errorCount++; $display("[TB] FAIL async_pre_state: got valid=%b rr=%0d expected 11/2", ifRr.cdb_valid, dutRr.rrPtr_q);
    end
    #2;
    rstN = 1'b0;
    #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b00 || ifRr.req_ready !== 4'b0000) begin
      errorCount++; $display("[TB] FAIL async_reset: got valid=%b ready=%b expected 00/0000", ifRr.cdb_valid, ifRr.req_ready);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkCount++;
    if (dutRr.rrPtr_q !== 2'd0 || ifRr.cdb_valid !== 2'b00) begin
      errorCount++; $display("[TB] FAIL async_release: got rr=%0d valid=%b expected 0/00", dutRr.rrPtr_q, ifRr.cdb_valid);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    ifRr.req_valid = 4'hF;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0011) begin
      errorCount++; $display("[TB] FAIL rr_ready0: got %b expected 0011", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b11 || ifRr.cdb_data[0] !== 32'hA0000000 || ifRr.cdb_data[1] !== 32'hA0000001) begin
      errorCount++; $display("[TB] FAIL rr_cdb0: got %b %h %h expected 11 a0000000 a0000001", ifRr.cdb_valid, ifRr.cdb_data[0], ifRr.cdb_data[1]);
    end
    checkCount++;
    if (ifRr.cdb_prd[0] !== 6'd10 || ifRr.cdb_prd[1] !== 6'd11 || ifRr.cdb_rob[1] !== 3'd1) begin
      errorCount++; $display("[TB] FAIL rr_tags0: got prd %0d %0d rob %0d expected 10 11 1", ifRr.cdb_prd[0], ifRr.cdb_prd[1], ifRr.cdb_rob[1]);
    end
    checkCount++;
    if (dutRr.rrPtr_q !== 2'd2 || dutRr.waitCnt_q[2] !== 4'd1 || dutRr.waitCnt_q[3] !== 4'd1) begin
      errorCount++; $display("[TB] FAIL rr_state0: got rr=%0d w2=%0d w3=%0d expected 2 1 1", dutRr.rrPtr_q, dutRr.waitCnt_q[2], dutRr.waitCnt_q[3]);
    end
    @(negedge clk);
    ifRr.req_valid = 4'b1100;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b1100) begin
      errorCount++; $display("[TB] FAIL rr_ready1: got %b expected 1100", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_data[0] !== 32'hA0000002 || ifRr.cdb_data[1] !== 32'hA0000003 || dutRr.rrPtr_q !== 2'd0) begin
      errorCount++; $display("[TB] FAIL rr_cdb1: got %h %h rr=%0d expected a0000002 a0000003 0", ifRr.cdb_data[0], ifRr.cdb_data[1], dutRr.rrPtr_q);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b00) begin
      errorCount++; $display("[TB] FAIL rr_idle: got %b expected 00", ifRr.cdb_valid);
    end
  endtask

  task automatic test_single_requester();
    @(negedge clk);
    ifRr.req_valid = 4'b1000;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b1000) begin
      errorCount++; $display("[TB] FAIL single_ready: got %b expected 1000", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b01 || ifRr.cdb_prd[0] !== 6'd13 || dutRr.rrPtr_q !== 2'd0) begin
      errorCount++; $display("[TB] FAIL single_cdb: got valid=%b prd=%0d rr=%0d expected 01 13 0", ifRr.cdb_valid, ifRr.cdb_prd[0], dutRr.rrPtr_q);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
  endtask

  task automatic test_regwrite_passthrough();
    @(negedge clk);
    ifRr.req_regwrite[2] = 1'b0;
    ifRr.req_data[2] = 32'hDEADBEEF;
    ifRr.req_rob[2] = 3'd5;
    ifRr.req_valid = 4'b0100;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0100) begin
      errorCount++; $display("[TB] FAIL nowrite_ready: got %b expected 0100", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid[0] !== 1'b1 || ifRr.cdb_regwrite[0] !== 1'b0 || ifRr.cdb_rob[0] !== 3'd5) begin
      errorCount++; $display("[TB] FAIL nowrite_ctrl: got v=%b rw=%b rob=%0d expected 1 0 5", ifRr.cdb_valid[0], ifRr.cdb_regwrite[0], ifRr.cdb_rob[0]);
    end
    checkCount++;
    if (ifRr.cdb_data[0] !== 32'hDEADBEEF || dutRr.rrPtr_q !== 2'd3) begin
      errorCount++; $display("[TB] FAIL nowrite_data: got %h rr=%0d expected deadbeef 3", ifRr.cdb_data[0], dutRr.rrPtr_q);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
    ifRr.req_regwrite[2] = 1'b1;
    ifRr.req_data[2] = 32'hA0000002;
    ifRr.req_rob[2] = 3'd2;
  endtask

  task automatic test_flush();
    @(negedge clk);
    ifRr.req_valid = 4'hF;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b1001) begin
      errorCount++; $display("[TB] FAIL wrap_ready: got %b expected 1001", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_prd[0] !== 6'd13 || ifRr.cdb_prd[1] !== 6'd10 || dutRr.rrPtr_q !== 2'd1 || dutRr.waitCnt_q[1] !== 4'd1) begin
      errorCount++; $display("[TB] FAIL wrap_cdb: got prd %0d %0d rr=%0d w1=%0d expected 13 10 1 1", ifRr.cdb_prd[0], ifRr.cdb_prd[1], dutRr.rrPtr_q, dutRr.waitCnt_q[1]);
    end
    @(negedge clk);
    ifRr.req_valid = 4'b0110;
    flushRr = 1'b1;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0000) begin
      errorCount++; $display("[TB] FAIL flush_ready: got %b expected 0000", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_valid !== 2'b00 || dutRr.waitCnt_q !== '0 || dutRr.rrPtr_q !== 2'd1) begin
      errorCount++; $display("[TB] FAIL flush_state: got valid=%b wait=%h rr=%0d expected 00 0 1", ifRr.cdb_valid, dutRr.waitCnt_q, dutRr.rrPtr_q);
    end
    @(negedge clk);
    flushRr = 1'b0;
    #1;
    checkCount++;
    if (ifRr.req_ready !== 4'b0110) begin
      errorCount++; $display("[TB] FAIL post_flush_ready: got %b expected 0110", ifRr.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifRr.cdb_prd[0] !== 6'd11 || ifRr.cdb_prd[1] !== 6'd12 || dutRr.rrPtr_q !== 2'd3) begin
      errorCount++; $display("[TB] FAIL post_flush_cdb: got prd %0d %0d rr=%0d expected 11 12 3", ifRr.cdb_prd[0], ifRr.cdb_prd[1], dutRr.rrPtr_q);
    end
    @(negedge clk);
    ifRr.req_valid = '0;
  endtask

  task automatic test_priority();
    logic [3:0] readyTable [3];
    logic [5:0] prdTable [3];
    readyTable[0] = 4'b0011; readyTable[1] = 4'b0101; readyTable[2] = 4'b1001;
    prdTable[0] = 6'd21;     prdTable[1] = 6'd22;     prdTable[2] = 6'd23;
    @(negedge clk);
    ifPrio.req_valid = 4'hF;
    for (int k = 0; k < 9; k++) begin
      #1;
      checkCount++;
      if (ifPrio.req_ready !== readyTable[k % 3]) begin
        errorCount++; $display("[TB] FAIL prio_ready[%0d]: got %b expected %b", k, ifPrio.req_ready, readyTable[k % 3]);
      end
      @(posedge clk); #1;
      checkCount++;
      if (ifPrio.cdb_valid !== 2'b11 || ifPrio.cdb_prd[0] !== 6'd20 || ifPrio.cdb_prd[1] !== prdTable[k % 3]) begin
        errorCount++; $display("[TB] FAIL prio_cdb[%0d]: got %b %0d %0d expected 11 20 %0d", k, ifPrio.cdb_valid, ifPrio.cdb_prd[0], ifPrio.cdb_prd[1], prdTable[k % 3]);
      end
      for (int i = 0; i < 4; i++) begin
        checkCount++;
        if (dutPrio.waitCnt_q[i] > 4'd2) begin
          errorCount++; $display("[TB] FAIL prio_wait[%0d][%0d]: got %0d expected <= 2", k, i, dutPrio.waitCnt_q[i]);
        end
      end
      @(negedge clk);
    end
    ifPrio.req_valid = '0;
  endtask

  task automatic test_starvation();
    @(negedge clk);
    ifStarve.req_valid = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkCount++;
      if (ifStarve.req_ready !== 4'b0001) begin
        errorCount++; $display("[TB] FAIL starve_ready[%0d]: got %b expected 0001", k, ifStarve.req_ready);
      end
      @(posedge clk); #1;
      checkCount++;
      if (dutStarve.waitCnt_q[1] !== 4'(k + 1) || ifStarve.cdb_prd[0] !== 6'd30) begin
        errorCount++; $display("[TB] FAIL starve_wait[%0d]: got w1=%0d prd=%0d expected %0d 30", k, dutStarve.waitCnt_q[1], ifStarve.cdb_prd[0], k + 1);
      end
      @(negedge clk);
    end
    #1;
    checkCount++;
    if (ifStarve.req_ready !== 4'b0010) begin
      errorCount++; $display("[TB] FAIL forced_ready: got %b expected 0010", ifStarve.req_ready);
    end
    @(posedge clk); #1;
    checkCount++;
    if (ifStarve.cdb_prd[0] !== 6'd31 || dutStarve.waitCnt_q[1] !== 4'd0 || dutStarve.waitCnt_q[0] !== 4'd1) begin
      errorCount++; $display("[TB] FAIL forced_cdb: got prd=%0d w1=%0d w0=%0d expected 31 0 1", ifStarve.cdb_prd[0], dutStarve.waitCnt_q[1], dutStarve.waitCnt_q[0]);
    end
    @(negedge clk); #1;
    checkCount++;
    if (ifStarve.req_ready !== 4'b0001 || dutStarve.rrPtr_q !== 2'd0) begin
      errorCount++; $display("[TB] FAIL after_forced: got ready=%b rr=%0d expected 0001 0", ifStarve.req_ready, dutStarve.rrPtr_q);
    end
    @(posedge clk);
    @(negedge clk);
    ifStarve.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_round_robin();
    test_single_requester();
    test_regwrite_passthrough();
    test_flush();
    test_priority();
    test_starvation();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
